// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks addresses 0..DEPTH-1 through a req/gnt-claimed memory port,
// routes each codeword via the external Hamming decoder and writes back corrected words.
module ecc_scrub_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic [11:0]       dec_code_out,
    input  logic [7:0]        dec_data_in,
    input  logic              dec_err_in,
    output logic [7:0]        enc_data_out,
    input  logic [11:0]       enc_code_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] last_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_CHK  = 3'd4,
        S_WR   = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [11:0]         rd_word_q, rd_word_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   last_err_q, last_err_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rd_word_q  <= 12'h000;
            wr_data_q  <= 8'h00;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_word_q  <= rd_word_d;
            wr_data_q  <= wr_data_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    // Sequencing: abort is honoured only in REQ and NEXT, where no access is in flight.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_word_d  = rd_word_q;
        wr_data_d  = wr_data_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_REQ;
                    ptr_d     = '0;
                    err_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mem_gnt) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                rd_word_d = mem_rdata;
                state_d   = S_CHK;
            end
            S_CHK: begin
                if (dec_err_in) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    last_err_d = ptr_q;
                    wr_data_d  = dec_data_in;
                    state_d    = S_WR;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WR: state_d = S_NEXT;
            S_NEXT: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d   = ptr_q + ADDR_ONE;
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode of port strobes and status, so reset removes them without waiting for a clock.
    always_comb begin
        mem_req   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 12'h000;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_REQ:  mem_req = 1'b1;
            S_RD: begin
                mem_req = 1'b1;
                mem_en  = 1'b1;
            end
            S_WAIT: mem_req = 1'b1;
            S_CHK:  mem_req = 1'b1;
            S_WR: begin
                mem_req   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = enc_code_in;
            end
            S_NEXT:  mem_req = 1'b0;
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign mem_addr      = ptr_q;
    assign dec_code_out  = rd_word_q;
    assign enc_data_out  = wr_data_q;
    assign err_count     = err_cnt_q;
    assign last_err_addr = last_err_q;

endmodule
